fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter DBITS, default 32: datapath and PC width.
REQ-002 Parameter START_PC, default 32'h40: PC loaded by reset.
REQ-003 Parameter FLUSH_CYCLES, default 2, legal range 1..15: number of noop cycles per redirect, counting the redirect cycle.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 stall  input  1  hazard hold request: freeze PC, block the F/D buffer write.
REQ-007 redirect  input  1  taken branch or jump from a later stage.
REQ-008 redirectPC  input  DBITS  redirect target; bits [1:0] are ignored and treated as 0.
REQ-009 imemAddr  output  DBITS  instruction memory address, equal to current PC.
REQ-010 imemData  input  DBITS  combinational instruction memory read data for imemAddr.
REQ-011 incPC_F  output  DBITS  PC+4, feeding the F/D buffer.
REQ-012 instWord_F  output  DBITS  fetched instruction, equal to imemData.
REQ-013 noop_F  output  1  marks the current F output as a bubble.
REQ-014 wrtEn_FD  output  1  write enable driven to the F/D buffer.

Function
REQ-015 State machine SHALL have four states: BOOT, RUN, STALL, SQUASH.
REQ-016 BOOT: PC holds START_PC; noop_F=1; wrtEn_FD=1; unconditionally moves to RUN on the next edge.
REQ-017 RUN, no redirect, no stall: PC <= PC+4; noop_F=0; wrtEn_FD=1.
REQ-018 RUN with stall=1 and redirect=0: PC held; wrtEn_FD=0; noop_F=0; next state STALL.
REQ-019 STALL: PC held; wrtEn_FD=0 while stall=1; when stall=0, behaves as RUN in that cycle and moves to RUN.
REQ-020 Redirect in RUN or STALL:
- noop_F=1 and wrtEn_FD=1 in that cycle;
- PC <= {redirectPC[DBITS-1:2], 2'b00};
- squash counter <= FLUSH_CYCLES-1;
- next state is SQUASH if FLUSH_CYCLES>1, else RUN.
REQ-021 SQUASH: noop_F=1; wrtEn_FD=1; PC held; counter decrements each cycle; moves to RUN in the cycle the counter reaches 0.
REQ-022 Priority is reset > redirect > stall; redirect is honoured in every state except BOOT.
REQ-023 In SQUASH, stall is ignored; redirect reloads the PC and the counter.
REQ-024 PC arithmetic is modulo 2^DBITS; incPC_F = PC+4 with wrap; no overflow flag.
REQ-025 imemAddr, incPC_F, instWord_F and noop_F are combinational from registered state and inputs, with zero-cycle latency to the F/D buffer inputs.

Reset
REQ-026 On an edge with reset=1: state <= BOOT; PC <= START_PC; squash counter <= 0.
REQ-027 In the cycle after reset: noop_F=1, wrtEn_FD=1, imemAddr=START_PC, incPC_F=START_PC+4.
REQ-028 Reset mid-SQUASH or mid-STALL SHALL discard the pending state and the counter with no residual noop cycles.

Structure
REQ-029 Package fetch_pkg SHALL hold the state enum, the PC_INC=4 constant and the default START_PC.
REQ-030 One sub-module, pc_reg, SHALL implement the PC register with hold/load/increment controls; the FSM and squash counter stay in fetch_stage.

Verification (START_PC=0x40, FLUSH_CYCLES=2)
REQ-031 Reset for 2 cycles, then release:
- first cycle: BOOT, noop_F=1, imemAddr=0x40;
- next: imemAddr=0x40, incPC_F=0x44, noop_F=0;
- then imemAddr=0x44.
REQ-032 stall=1 for 3 cycles at PC 0x48 -> wrtEn_FD=0 for 3 cycles, imemAddr=0x48 throughout; the first cycle after release shows 0x48 with wrtEn_FD=1, then 0x4C.
REQ-033 redirect=1 with redirectPC=0x103 at PC 0x50:
- that cycle: noop_F=1;
- next: imemAddr=0x100, noop_F=1;
- next: imemAddr=0x100, noop_F=0;
- then 0x104.
REQ-034 redirect=1 and stall=1 in the same cycle -> redirect wins: wrtEn_FD=1, PC loads the target, state SQUASH.
REQ-035 PC=0xFFFFFFFC in RUN -> incPC_F=0x0; next imemAddr=0x0.
REQ-036 reset asserted during SQUASH -> next cycle BOOT, imemAddr=0x40, noop_F=1; normal RUN follows with no extra bubbles.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int PC_INC = 4;
  localparam logic [31:0] DEFAULT_START_PC = 32'h40;
  localparam int CNT_BITS = 4;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    STALL  = 2'd2,
    SQUASH = 2'd3
  } fetchState_t;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_LOAD = 2'd1,
    PC_STEP = 2'd2
  } pcOp_t;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register with hold / load / increment control.
module pc_reg
  import fetch_pkg::*;
#(
  parameter int DBITS = 32,
  parameter logic [DBITS-1:0] START_PC = DBITS'(DEFAULT_START_PC)
) (
  input  logic             clk,
  input  logic             reset,
  input  pcOp_t            pcOp,
  input  logic [DBITS-1:0] loadPC,
  output logic [DBITS-1:0] pc,
  output logic [DBITS-1:0] pcPlus4
);

  // Wraps modulo 2^DBITS by construction.
  assign pcPlus4 = pc + DBITS'(PC_INC);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= START_PC;
    end else begin
      case (pcOp)
        PC_LOAD: pc <= loadPC;
        PC_STEP: pc <= pcPlus4;
        default: pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, stall hold and post-redirect bubble insertion.
//
// state  | meaning
// BOOT   | first cycle after reset, emits a bubble at START_PC
// RUN    | normal fetch, PC advances by 4 each cycle
// STALL  | hazard hold, PC frozen and F/D write blocked
// SQUASH | bubbles after a redirect while squashCnt runs down
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int DBITS = 32,
  parameter logic [DBITS-1:0] START_PC = DBITS'(DEFAULT_START_PC),
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic [DBITS-1:0] redirectPC,
  output logic [DBITS-1:0] imemAddr,
  input  logic [DBITS-1:0] imemData,
  output logic [DBITS-1:0] incPC_F,
  output logic [DBITS-1:0] instWord_F,
  output logic             noop_F,
  output logic             wrtEn_FD
);

  localparam logic [CNT_BITS-1:0] FLUSH_LOAD = CNT_BITS'(FLUSH_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE    = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] CNT_ZERO   = '0;
  // A single-cycle flush is fully covered by the redirect cycle itself.
  localparam fetchState_t REDIRECT_STATE = (FLUSH_CYCLES > 1) ? SQUASH : RUN;

  fetchState_t         state, nextState;
  logic [CNT_BITS-1:0] squashCnt, nextCnt;
  pcOp_t               pcOp;
  logic [DBITS-1:0]    pc, pcPlus4, redirectAligned;

  assign redirectAligned = redirectPC & ~DBITS'(3);

  pc_reg #(
    .DBITS    (DBITS),
    .START_PC (START_PC)
  ) pcReg (
    .clk     (clk),
    .reset   (reset),
    .pcOp    (pcOp),
    .loadPC  (redirectAligned),
    .pc      (pc),
    .pcPlus4 (pcPlus4)
  );

  assign imemAddr   = pc;
  assign incPC_F    = pcPlus4;
  assign instWord_F = imemData;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= BOOT;
      squashCnt <= CNT_ZERO;
    end else begin
      state     <= nextState;
      squashCnt <= nextCnt;
    end
  end

  always_comb begin
    nextState = state;
    nextCnt   = squashCnt;
    pcOp      = PC_HOLD;
    noop_F    = 1'b0;
    wrtEn_FD  = 1'b1;
    case (state)
      BOOT: begin
        noop_F    = 1'b1;
        nextState = RUN;
      end
      RUN, STALL: begin
        if (redirect) begin
          noop_F    = 1'b1;
          pcOp      = PC_LOAD;
          nextCnt   = FLUSH_LOAD;
          nextState = REDIRECT_STATE;
        end else if (stall) begin
          wrtEn_FD  = 1'b0;
          nextState = STALL;
        end else begin
          pcOp      = PC_STEP;
          nextState = RUN;
        end
      end
      SQUASH: begin
        noop_F = 1'b1;
        if (redirect) begin
          pcOp      = PC_LOAD;
          nextCnt   = FLUSH_LOAD;
          nextState = REDIRECT_STATE;
        end else begin
          // Terminal count: leave when the decrement lands on zero.
          nextCnt = (squashCnt == CNT_ZERO) ? CNT_ZERO : squashCnt - CNT_ONE;
          if (squashCnt <= CNT_ONE) begin
            nextState = RUN;
          end
        end
      end
      default: begin
        nextState = BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed corner sequences followed by random stall/redirect/reset traffic.
module tb_fetch_stage;

  localparam int          DBITS = 32;
  localparam logic [31:0] START = 32'h40;
  localparam int          FLUSH = 2;

  logic        clk = 1'b0;
  logic        reset, stall, redirect;
  logic [31:0] redirectPC, imemAddr, imemData, incPC_F, instWord_F;
  logic        noop_F, wrtEn_FD;

  fetch_stage #(
    .DBITS        (DBITS),
    .START_PC     (START),
    .FLUSH_CYCLES (FLUSH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .redirect   (redirect),
    .redirectPC (redirectPC),
    .imemAddr   (imemAddr),
    .imemData   (imemData),
    .incPC_F    (incPC_F),
    .instWord_F (instWord_F),
    .noop_F     (noop_F),
    .wrtEn_FD   (wrtEn_FD)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  assign imemData = memWord(imemAddr);

  typedef struct {
    bit          chk;
    logic [31:0] addr, inc, inst;
    logic        noop, wrt;
    bit          ca;
    logic [31:0] ea;
    int          en, ew;
  } exp_t;

  exp_t expQ[$];
  int   passCnt = 0;
  int   totalCnt = 0;
  bit   started = 0;
  bit   done = 0;

  // Reference model: fetch address, remaining bubbles after a redirect, boot flag.
  logic [31:0] mPc;
  bit          mBoot = 0;
  int          mBub = 0;
  bit          mKnown = 0;

  task automatic step(input bit r, input bit s, input bit d, input logic [31:0] t,
                      input bit ca, input logic [31:0] ea, input int en, input int ew);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r; stall = s; redirect = d; redirectPC = t;
    e.chk = mKnown;
    e.ca = ca; e.ea = ea; e.en = en; e.ew = ew;
    e.addr = mPc; e.inc = mPc + 32'd4; e.inst = memWord(mPc);
    if (mBoot)         begin e.noop = 1; e.wrt = 1; end
    else if (d)        begin e.noop = 1; e.wrt = 1; end
    else if (mBub > 0) begin e.noop = 1; e.wrt = 1; end
    else if (s)        begin e.noop = 0; e.wrt = 0; end
    else               begin e.noop = 0; e.wrt = 1; end
    if (r) begin
      mPc = START; mBoot = 1; mBub = 0; mKnown = 1;
    end else if (mBoot) begin
      mBoot = 0;
    end else if (d) begin
      mPc = t & 32'hFFFF_FFFC; mBub = FLUSH - 1;
    end else if (mBub > 0) begin
      mBub = mBub - 1;
    end else if (!s) begin
      mPc = mPc + 32'd4;
    end
    expQ.push_back(e);
    started = 1;
  endtask

  task automatic run(input bit r, input bit s, input bit d, input logic [31:0] t);
    step(r, s, d, t, 0, 32'h0, -1, -1);
  endtask

  // Monitor: one F-stage output per cycle, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (started && !done) begin
        if (expQ.size() == 0) begin
          totalCnt++;
          $display("FAIL queue: output with no expectation at %0t", $time);
        end else begin
          e = expQ.pop_front();
          if (e.chk) begin
            totalCnt++;
            if (imemAddr === e.addr && incPC_F === e.inc && instWord_F === e.inst &&
                noop_F === e.noop && wrtEn_FD === e.wrt)
              passCnt++;
            else
              $display("FAIL out t=%0t actual addr=%h inc=%h inst=%h noop=%b wrt=%b required addr=%h inc=%h inst=%h noop=%b wrt=%b",
                       $time, imemAddr, incPC_F, instWord_F, noop_F, wrtEn_FD,
                       e.addr, e.inc, e.inst, e.noop, e.wrt);
          end
          if (e.ca) begin
            totalCnt++;
            if (imemAddr === e.ea) passCnt++;
            else $display("FAIL dirAddr t=%0t actual %h required %h", $time, imemAddr, e.ea);
          end
          if (e.en >= 0) begin
            totalCnt++;
            if (noop_F === e.en[0]) passCnt++;
            else $display("FAIL dirNoop t=%0t actual %b required %0d", $time, noop_F, e.en);
          end
          if (e.ew >= 0) begin
            totalCnt++;
            if (wrtEn_FD === e.ew[0]) passCnt++;
            else $display("FAIL dirWrt t=%0t actual %b required %0d", $time, wrtEn_FD, e.ew);
          end
        end
      end
    end
  end

  initial begin
    reset = 1; stall = 0; redirect = 0; redirectPC = '0;
    // Reset and boot
    run(1, 0, 0, 0);
    run(1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h40, 1, 1);
    step(0, 0, 0, 0, 1, 32'h40, 0, 1);
    step(0, 0, 0, 0, 1, 32'h44, 0, 1);
    // Stall for three cycles at 0x48
    step(0, 1, 0, 0, 1, 32'h48, 0, 0);
    step(0, 1, 0, 0, 1, 32'h48, 0, 0);
    step(0, 1, 0, 0, 1, 32'h48, 0, 0);
    step(0, 0, 0, 0, 1, 32'h48, 0, 1);
    step(0, 0, 0, 0, 1, 32'h4C, 0, 1);
    // Redirect to 0x103 at 0x50
    step(0, 0, 1, 32'h103, 1, 32'h50, 1, 1);
    step(0, 0, 0, 0, 1, 32'h100, 1, 1);
    step(0, 0, 0, 0, 1, 32'h100, 0, 1);
    step(0, 0, 0, 0, 1, 32'h104, 0, 1);
    // Redirect beats stall; stall ignored in SQUASH
    step(0, 1, 1, 32'h200, 1, 32'h108, 1, 1);
    step(0, 1, 0, 0, 1, 32'h200, 1, 1);
    step(0, 0, 0, 0, 1, 32'h200, 0, 1);
    step(0, 0, 0, 0, 1, 32'h204, 0, 1);
    // PC wrap
    step(0, 0, 1, 32'hFFFF_FFF9, 1, 32'h208, 1, 1);
    run(0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'hFFFF_FFF8, 0, 1);
    step(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 1);
    step(0, 0, 0, 0, 1, 32'h0, 0, 1);
    // Reset during SQUASH
    step(0, 0, 1, 32'h300, 1, 32'h4, 1, 1);
    step(1, 0, 0, 0, 1, 32'h300, 1, 1);
    step(0, 0, 0, 0, 1, 32'h40, 1, 1);
    step(0, 0, 0, 0, 1, 32'h40, 0, 1);
    step(0, 0, 0, 0, 1, 32'h44, 0, 1);
    // Reset during STALL
    run(0, 1, 0, 0);
    run(0, 1, 0, 0);
    step(1, 1, 0, 0, 1, 32'h48, 0, 0);
    step(0, 0, 0, 0, 1, 32'h40, 1, 1);
    step(0, 0, 0, 0, 1, 32'h40, 0, 1);
    // Random traffic
    for (int i = 0; i < 600; i++) begin
      run($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 30,
          $urandom_range(0, 99) < 10, $urandom);
    end
    run(0, 0, 0, 0);
    @(negedge clk);
    #1;
    done = 1;
    if (expQ.size() != 0) begin
      totalCnt++;
      $display("FAIL drain: %0d expectations left, required 0", expQ.size());
    end
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
